// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge initiator for an 8086-mode controller.
// Synchronizes INT, issues two active-low INTA pulses, captures the vector
// driven during the second pulse and hands it to the CPU core over a
// valid/ack handshake. A holdoff window follows each handoff so the
// controller's INT fall can propagate through the synchronizer.
module inta_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 2,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned HOLDOFF_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ack,
    output logic       busy
);

    localparam int unsigned MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_N  = (MAX_PG > HOLDOFF_CYCLES) ? MAX_PG : HOLDOFF_CYCLES;
    localparam int unsigned CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK1,
        S_GAP,
        S_ACK2,
        S_HANDOFF,
        S_HOLDOFF
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_inta_n;
    logic [7:0]    r_vector;
    logic          r_valid;
    logic          w_int_sync;
    logic          w_cnt_zero;

    assign w_int_sync = r_sync2;
    assign w_cnt_zero = (r_cnt == '0);

    // Two-flop synchronizer for the asynchronous INT request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= int_req;
            r_sync2 <= r_sync1;
        end
    end

    // Acknowledge sequencer: state, dwell counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_inta_n <= 1'b1;
            r_vector <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_int_sync && int_enable) begin
                        r_state  <= S_ACK1;
                        r_cnt    <= PULSE_LOAD;
                        r_inta_n <= 1'b0;
                    end
                end
                S_ACK1: begin
                    if (w_cnt_zero) begin
                        r_state  <= S_GAP;
                        r_cnt    <= GAP_LOAD;
                        r_inta_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        r_state  <= S_ACK2;
                        r_cnt    <= PULSE_LOAD;
                        r_inta_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACK2: begin
                    if (w_cnt_zero) begin
                        r_state  <= S_HANDOFF;
                        r_vector <= data_in;
                        r_inta_n <= 1'b1;
                        r_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HANDOFF: begin
                    // valid is already high here, so an ack seen on the
                    // capture edge (still in ACK2) is never consumed
                    if (vector_ack) begin
                        r_state <= S_HOLDOFF;
                        r_cnt   <= HOLDOFF_LOAD;
                        r_valid <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_inta_n <= 1'b1;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign inta_n       = r_inta_n;
    assign vector       = r_vector;
    assign vector_valid = r_valid;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default timing, handshake stalls,
// enable gating, atomic sequence, async reset mid-pulse, and a short-timing
// instance with INT held high for back-to-back sequences.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       int_req, int_enable, vector_ack;
    logic [7:0] data_in;
    logic       inta_n, vector_valid, busy;
    logic [7:0] vector;

    logic       b_int_req, b_int_enable, b_vector_ack;
    logic [7:0] b_data_in;
    logic       b_inta_n, b_vector_valid, b_busy;
    logic [7:0] b_vector;

    int checks   = 0;
    int failures = 0;

    inta_sequencer dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (int_req),
        .int_enable   (int_enable),
        .data_in      (data_in),
        .inta_n       (inta_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ack   (vector_ack),
        .busy         (busy)
    );

    inta_sequencer #(
        .PULSE_CYCLES   (1),
        .GAP_CYCLES     (3),
        .HOLDOFF_CYCLES (1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (b_int_req),
        .int_enable   (b_int_enable),
        .data_in      (b_data_in),
        .inta_n       (b_inta_n),
        .vector       (b_vector),
        .vector_valid (b_vector_valid),
        .vector_ack   (b_vector_ack),
        .busy         (b_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] pat_inta;
        logic [7:0] pat_valid;
        logic [7:0] pat_busy;

        rst_n        = 1'b0;
        int_req      = 1'b0;
        int_enable   = 1'b0;
        vector_ack   = 1'b0;
        data_in      = 8'h00;
        b_int_req    = 1'b0;
        b_int_enable = 1'b0;
        b_vector_ack = 1'b0;
        b_data_in    = 8'h00;

        // Reset state
        tick();
        tick();
        chk1("rst_inta_n", inta_n, 1'b1);
        chk8("rst_vector", vector, 8'h00);
        chk1("rst_valid", vector_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_b_inta_n", b_inta_n, 1'b1);
        rst_n = 1'b1;
        tick();
        tick();

        // Default sequence: 3-edge latency, 2/2/2 pulse shape, capture at E+6
        int_enable = 1'b1;
        int_req    = 1'b1;
        tick();
        chk1("t1_edge1_inta", inta_n, 1'b1);
        int_req = 1'b0;
        tick();
        chk1("t1_edge2_inta", inta_n, 1'b1);
        tick();
        chk1("t1_E_inta", inta_n, 1'b0);
        chk1("t1_E_busy", busy, 1'b1);
        tick();
        chk1("t1_E1_inta", inta_n, 1'b0);
        tick();
        chk1("t1_E2_inta", inta_n, 1'b1);
        tick();
        chk1("t1_E3_inta", inta_n, 1'b1);
        data_in = 8'h4A;
        tick();
        chk1("t1_E4_inta", inta_n, 1'b0);
        tick();
        chk1("t1_E5_inta", inta_n, 1'b0);
        chk1("t1_E5_valid", vector_valid, 1'b0);
        tick();
        chk1("t1_E6_inta", inta_n, 1'b1);
        chk1("t1_E6_valid", vector_valid, 1'b1);
        chk8("t1_E6_vector", vector, 8'h4A);
        chk1("t1_E6_busy", busy, 1'b1);

        // Stalled handoff: valid and vector hold until the ack edge
        data_in = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("t2_stall_valid", vector_valid, 1'b1);
            chk8("t2_stall_vector", vector, 8'h4A);
        end
        vector_ack = 1'b1;
        tick();
        chk1("t2_ack_valid", vector_valid, 1'b0);
        chk8("t2_ack_vector", vector, 8'h4A);
        chk1("t2_ack_busy", busy, 1'b1);
        vector_ack = 1'b0;
        tick();
        chk1("t2_hold1_busy", busy, 1'b1);
        tick();
        chk1("t2_hold2_busy", busy, 1'b1);
        tick();
        chk1("t2_idle_busy", busy, 1'b0);
        chk1("t2_idle_inta", inta_n, 1'b1);

        // Enable gating: request pending but disabled
        int_enable = 1'b0;
        int_req    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("t3_gated_inta", inta_n, 1'b1);
            chk1("t3_gated_busy", busy, 1'b0);
        end
        int_enable = 1'b1;
        tick();
        chk1("t3_start_inta", inta_n, 1'b0);
        chk1("t3_start_busy", busy, 1'b1);

        // Atomic sequence: enable and request drop during GAP
        tick();
        chk1("t4_E1_inta", inta_n, 1'b0);
        tick();
        chk1("t4_E2_inta", inta_n, 1'b1);
        int_enable = 1'b0;
        int_req    = 1'b0;
        data_in    = 8'h27;
        tick();
        chk1("t4_E3_inta", inta_n, 1'b1);
        tick();
        chk1("t4_E4_inta", inta_n, 1'b0);
        tick();
        chk1("t4_E5_inta", inta_n, 1'b0);
        // ack already high on the capture edge must not be consumed there
        vector_ack = 1'b1;
        tick();
        chk1("t4_E6_inta", inta_n, 1'b1);
        chk1("t4_E6_valid", vector_valid, 1'b1);
        chk8("t4_E6_vector", vector, 8'h27);
        tick();
        chk1("t4_E7_valid", vector_valid, 1'b0);
        chk1("t4_E7_busy", busy, 1'b1);
        vector_ack = 1'b0;
        tick();
        chk1("t4_E8_busy", busy, 1'b1);
        tick();
        chk1("t4_E9_busy", busy, 1'b1);
        tick();
        chk1("t4_E10_busy", busy, 1'b0);
        tick();
        chk1("t4_quiet_inta", inta_n, 1'b1);
        chk1("t4_quiet_busy", busy, 1'b0);

        // Async reset in the middle of ACK2
        int_enable = 1'b1;
        int_req    = 1'b1;
        tick();
        int_req = 1'b0;
        tick();
        tick();
        chk1("t5_E_inta", inta_n, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk1("t5_E4_inta", inta_n, 1'b0);
        data_in = 8'h99;
        tick();
        chk1("t5_E5_inta", inta_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t5_rst_inta", inta_n, 1'b1);
        chk1("t5_rst_valid", vector_valid, 1'b0);
        chk8("t5_rst_vector", vector, 8'h00);
        chk1("t5_rst_busy", busy, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t5_post_inta", inta_n, 1'b1);
            chk1("t5_post_busy", busy, 1'b0);
        end
        int_req = 1'b1;
        tick();
        chk1("t5_re_edge1_inta", inta_n, 1'b1);
        int_req = 1'b0;
        tick();
        chk1("t5_re_edge2_inta", inta_n, 1'b1);
        tick();
        chk1("t5_re_E_inta", inta_n, 1'b0);

        // Clean slate for the short-timing instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Short timing 1/3/1/1, INT held, ack held: period of 8 edges
        b_int_enable = 1'b1;
        b_vector_ack = 1'b1;
        b_data_in    = 8'hC3;
        b_int_req    = 1'b1;
        tick();
        chk1("t6_edge1_inta", b_inta_n, 1'b1);
        tick();
        chk1("t6_edge2_inta", b_inta_n, 1'b1);
        chk1("t6_edge2_busy", b_busy, 1'b0);
        // bit i = expected value at edge E+i (mod 8)
        pat_inta  = 8'b1110_1110;
        pat_valid = 8'b0010_0000;
        pat_busy  = 8'b0111_1111;
        for (int i = 0; i <= 16; i++) begin
            tick();
            chk1($sformatf("t6_inta_E%0d", i), b_inta_n, pat_inta[i % 8]);
            chk1($sformatf("t6_valid_E%0d", i), b_vector_valid, pat_valid[i % 8]);
            chk1($sformatf("t6_busy_E%0d", i), b_busy, pat_busy[i % 8]);
            if (i == 5) chk8("t6_vector_first", b_vector, 8'hC3);
            if (i == 13) chk8("t6_vector_second", b_vector, 8'h3C);
            if (i == 6) b_data_in = 8'h3C;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
